// File: rtl/counter_pkg.sv
// Shared encodings for counter_mod: terminal-behaviour modes and one-shot FSM states.
// Pure declarations: no logic, no latency, no flow control.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: tick is high on every PRESCALE-th cycle with en_in high; combinational tick, phase state is registered.
// No backpressure; clr and rst (active-low) restart the phase from zero.
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en_in,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en_in && (phase == LAST);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      phase <= '0;
    end else if (en_in) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/counter_mod.sv
// Modulo-MOD up/down counter with load, wrap/saturate/one-shot terminal modes; 1-cycle step latency, no backpressure.
// Optional enable prescaler built only when COUNTER_MOD_PRESCALE_EN is defined.
module counter_mod
  import counter_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int MOD      = 256,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cnt,
  input  logic            dir,
  input  logic [1:0]      mode,
  input  logic            load,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] val,
  output logic            tc,
  output logic            ovf,
  output logic            done
);

  localparam logic [BITS-1:0] TOP     = BITS'(MOD - 1);
  localparam logic [BITS:0]   MOD_EXT = (BITS + 1)'(MOD);

  state_t          state;
  logic            en;
  logic [BITS-1:0] load_val;

`ifdef COUNTER_MOD_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (load),
    .en_in (cnt),
    .tick  (en)
  );
`else
  assign en = cnt;
`endif

  // Widen by one bit so MOD == 2**BITS compares correctly and never clamps.
  assign load_val = ({1'b0, din} >= MOD_EXT) ? TOP : din;
  assign tc       = dir ? (val == TOP) : (val == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      val   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else if (load) begin
      val   <= load_val;
      ovf   <= 1'b0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else begin
      ovf <= 1'b0;
      case (state)
        ST_RUN: begin
          if (en) begin
            if (!tc) begin
              val <= dir ? val + BITS'(1) : val - BITS'(1);
            end else begin
              case (mode)
                MODE_SAT: ;
                MODE_ONESHOT: begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  ovf   <= 1'b1;
                end
                default: begin
                  val <= dir ? '0 : TOP;
                  ovf <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_DONE: begin
          // Frozen until load/reset, or until software switches away from one-shot.
          if (mode != MODE_ONESHOT) begin
            state <= ST_RUN;
            done  <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
